// File: rtl/npu_pio_pkg.sv
// Shared types for the PIO command front end: command word layouts, status bit
// positions and dispatch FSM states.
package npu_pio_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_MOVE  = 2'b10,
    OP_SYS   = 2'b11
  } op_e;

  typedef struct packed {
    op_e         op;
    logic [8:0]  line;
    logic [12:0] addr;
    logic [7:0]  len;
  } ldst_cmd_t;

  typedef struct packed {
    op_e        op;
    logic [9:0] src;
    logic [9:0] dst;
    logic [1:0] rsvd;
    logic [7:0] len;
  } mv_cmd_t;

  typedef union packed {
    ldst_cmd_t   ldst;
    mv_cmd_t     mv;
    logic [31:0] raw;
  } cmd_t;

  localparam int ST_MV_DONE   = 31;
  localparam int ST_LDST_DONE = 30;
  localparam int ST_BUSY      = 29;
  localparam int ST_ERR_OVF   = 28;
  localparam int ST_ERR_ILL   = 27;
  localparam int ST_CNT_MSB   = 23;
  localparam int ST_CNT_LSB   = 20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } disp_state_e;

endpackage

// File: rtl/pio_cmd_fifo.sv
// Synchronous command FIFO of 32-bit words; exposes the registered occupancy and
// the occupancy it will hold after this edge.
module pio_cmd_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [31:0]   wdata,
  input  logic          pop,
  output logic [31:0]   rdata,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every signal written here gets its default first, so no path can leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // NOTE: flops take non-blocking assignments so every register samples pre-edge values regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; reset empties the FIFO through the pointers, so stale words are never read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign count_nxt = count_d;

endmodule

// File: rtl/pio_cmd_dispatch.sv
// Host PIO front end: decodes and queues command words, issues them one at a time
// to the load/store or move engine, and reports completion/error status.
module pio_cmd_dispatch
  import npu_pio_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] h2f_pio32,
  input  logic        h2f_write,
  output logic [31:0] f2h_pio32,
  output logic        f2h_write,
  output logic        ldst_valid,
  input  logic        ldst_ready,
  output logic        ldst_is_store,
  output logic [8:0]  ldst_line,
  output logic [12:0] ldst_addr,
  output logic [7:0]  ldst_len,
  input  logic        ldst_done,
  output logic        mv_valid,
  input  logic        mv_ready,
  output logic [9:0]  mv_src,
  output logic [9:0]  mv_dst,
  output logic [7:0]  mv_len,
  input  logic        mv_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  cmd_t          in_cmd;
  logic          in_sys, cmd_clr, cmd_ill, q_req, fifo_full, fifo_push, fifo_pop, ovf;
  logic [31:0]   fifo_rdata;
  logic [CW-1:0] fifo_count, fifo_count_nxt;

  disp_state_e      state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic             cur_is_mv;
  logic             mv_done_q, mv_done_d, ldst_done_q, ldst_done_d;
  logic             err_ovf_q, err_ovf_d, err_ill_q, err_ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      status_q, status_d;
  logic             f2h_write_q, f2h_write_d;

  assign in_cmd    = cmd_t'(h2f_pio32);
  assign in_sys    = h2f_write && (in_cmd.ldst.op == OP_SYS);
  assign cmd_clr   = in_sys && (in_cmd.raw[29:0] == '0);
  assign cmd_ill   = in_sys && (in_cmd.raw[29:0] != '0);
  assign q_req     = h2f_write && (in_cmd.ldst.op != OP_SYS);
  // Full is judged on the registered count, so a same-cycle pop never rescues a push.
  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_push = q_req && !fifo_full;
  assign ovf       = q_req && fifo_full;

  pio_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .wdata     (h2f_pio32),
    .pop       (fifo_pop),
    .rdata     (fifo_rdata),
    .count     (fifo_count),
    .count_nxt (fifo_count_nxt)
  );

  assign cur_is_mv = (cmd_q.ldst.op == OP_MOVE);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    fifo_pop    = 1'b0;
    mv_done_d   = mv_done_q;
    ldst_done_d = ldst_done_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (fifo_count != '0) begin
          fifo_pop = 1'b1;
          cmd_d    = cmd_t'(fifo_rdata);
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cur_is_mv ? mv_ready : ldst_ready) begin
          state_d = S_WAIT;
          if (cur_is_mv) mv_done_d   = 1'b0;
          else           ldst_done_d = 1'b0;
        end
      end
      S_WAIT: begin
        // Only the outstanding engine's done retires the command.
        if (cur_is_mv ? mv_done : ldst_done) begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + 1'b1;
          if (cur_is_mv) mv_done_d   = 1'b1;
          else           ldst_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    err_ovf_d = err_ovf_q;
    err_ill_d = err_ill_q;
    if (cmd_clr) begin
      err_ovf_d = 1'b0;
      err_ill_d = 1'b0;
    end
    // Errors are applied after CLR so a coincident error wins.
    if (ovf)     err_ovf_d = 1'b1;
    if (cmd_ill) err_ill_d = 1'b1;
  end

  always_comb begin
    status_d                         = '0;
    status_d[ST_MV_DONE]             = mv_done_d;
    status_d[ST_LDST_DONE]           = ldst_done_d;
    status_d[ST_BUSY]                = (fifo_count_nxt != '0) || (state_d != S_IDLE);
    status_d[ST_ERR_OVF]             = err_ovf_d;
    status_d[ST_ERR_ILL]             = err_ill_d;
    status_d[ST_CNT_MSB:ST_CNT_LSB]  = 4'(fifo_count_nxt);
    status_d[CNT_W-1:0]              = cnt_d;
    // The strobe is registered alongside the word so it accompanies the new value.
    f2h_write_d                      = (status_d != status_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      mv_done_q   <= 1'b0;
      ldst_done_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_ill_q   <= 1'b0;
      cnt_q       <= '0;
      status_q    <= '0;
      f2h_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      mv_done_q   <= mv_done_d;
      ldst_done_q <= ldst_done_d;
      err_ovf_q   <= err_ovf_d;
      err_ill_q   <= err_ill_d;
      cnt_q       <= cnt_d;
      status_q    <= status_d;
      f2h_write_q <= f2h_write_d;
    end
  end

  assign ldst_valid    = (state_q == S_ISSUE) && !cur_is_mv;
  assign mv_valid      = (state_q == S_ISSUE) && cur_is_mv;
  assign ldst_is_store = (cmd_q.ldst.op == OP_STORE);
  assign ldst_line     = cmd_q.ldst.line;
  assign ldst_addr     = cmd_q.ldst.addr;
  assign ldst_len      = cmd_q.ldst.len;
  assign mv_src        = cmd_q.mv.src;
  assign mv_dst        = cmd_q.mv.dst;
  assign mv_len        = cmd_q.mv.len;
  assign f2h_pio32     = status_q;
  assign f2h_write     = f2h_write_q;

endmodule
